// File: rtl/id_ex_operand_stage_if.sv
// ID -> EX operand-stage bus: decoded instruction in, forwarding sources, ALU operands out.
interface id_ex_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 10
);
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1_addr;
    logic [4:0]      id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_use_pc;
    logic            id_use_imm;
    logic [OPW-1:0]  id_alu_op;
    logic [4:0]      id_rd_addr;
    logic            id_rd_we;
    logic            flush;
    logic            ex_ready;
    logic            mem_rd_we;
    logic [4:0]      mem_rd_addr;
    logic [XLEN-1:0] mem_rd_num;
    logic            wb_rd_we;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_rd_num;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] rs1_num;
    logic [XLEN-1:0] rs2_num;
    logic [OPW-1:0]  alu_op;
    logic [4:0]      ex_rd_addr;
    logic            ex_rd_we;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_pc, id_use_imm, id_alu_op, id_rd_addr, id_rd_we,
               flush, ex_ready, mem_rd_we, mem_rd_addr, mem_rd_num,
               wb_rd_we, wb_rd_addr, wb_rd_num,
        input  id_ready, ex_valid, ex_pc, rs1_num, rs2_num, alu_op, ex_rd_addr, ex_rd_we
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_pc, id_use_imm, id_alu_op, id_rd_addr, id_rd_we,
               flush, ex_ready, mem_rd_we, mem_rd_addr, mem_rd_num,
               wb_rd_we, wb_rd_addr, wb_rd_num,
        output id_ready, ex_valid, ex_pc, rs1_num, rs2_num, alu_op, ex_rd_addr, ex_rd_we
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the RV32I ALU.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 10
) (
    input logic              clk,
    input logic              rst,
    id_ex_operand_stage_if.slave bus
);

    logic            ex_valid_r;
    logic [XLEN-1:0] pc_r;
    logic [4:0]      rs1_addr_r;
    logic [4:0]      rs2_addr_r;
    logic [XLEN-1:0] rs1_data_r;
    logic [XLEN-1:0] rs2_data_r;
    logic [XLEN-1:0] imm_r;
    logic            use_pc_r;
    logic            use_imm_r;
    logic [OPW-1:0]  alu_op_r;
    logic [4:0]      rd_addr_r;
    logic            rd_we_r;

    logic            id_ready_s;
    logic            load_s;
    logic [XLEN-1:0] fwd1_s;
    logic [XLEN-1:0] fwd2_s;

    // MEM beats WB; x0 always reads the stored value.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      a,
        input logic [XLEN-1:0] d,
        input logic            mwe,
        input logic [4:0]      ma,
        input logic [XLEN-1:0] mn,
        input logic            wwe,
        input logic [4:0]      wa,
        input logic [XLEN-1:0] wn
    );
        if (mwe && (ma == a) && (a != 5'd0)) begin
            return mn;
        end else if (wwe && (wa == a) && (a != 5'd0)) begin
            return wn;
        end else begin
            return d;
        end
    endfunction

    assign id_ready_s = !ex_valid_r || bus.ex_ready;
    assign load_s     = bus.id_valid && id_ready_s && !bus.flush;

    assign fwd1_s = fwd_sel(rs1_addr_r, rs1_data_r, bus.mem_rd_we, bus.mem_rd_addr, bus.mem_rd_num,
                            bus.wb_rd_we, bus.wb_rd_addr, bus.wb_rd_num);
    assign fwd2_s = fwd_sel(rs2_addr_r, rs2_data_r, bus.mem_rd_we, bus.mem_rd_addr, bus.mem_rd_num,
                            bus.wb_rd_we, bus.wb_rd_addr, bus.wb_rd_num);

    // Stage register: flush > load > hold (with forwarded-value refresh) > drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            pc_r       <= '0;
            rs1_addr_r <= 5'd0;
            rs2_addr_r <= 5'd0;
            rs1_data_r <= '0;
            rs2_data_r <= '0;
            imm_r      <= '0;
            use_pc_r   <= 1'b0;
            use_imm_r  <= 1'b0;
            alu_op_r   <= '0;
            rd_addr_r  <= 5'd0;
            rd_we_r    <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_r <= 1'b0;
        end else if (load_s) begin
            ex_valid_r <= 1'b1;
            pc_r       <= bus.id_pc;
            rs1_addr_r <= bus.id_rs1_addr;
            rs2_addr_r <= bus.id_rs2_addr;
            rs1_data_r <= bus.id_rs1_data;
            rs2_data_r <= bus.id_rs2_data;
            imm_r      <= bus.id_imm;
            use_pc_r   <= bus.id_use_pc;
            use_imm_r  <= bus.id_use_imm;
            alu_op_r   <= bus.id_alu_op;
            rd_addr_r  <= bus.id_rd_addr;
            rd_we_r    <= bus.id_rd_we;
        end else if (ex_valid_r && !bus.ex_ready) begin
            // Capture forwarded values so they survive the producer retiring.
            rs1_data_r <= fwd1_s;
            rs2_data_r <= fwd2_s;
        end else if (ex_valid_r) begin
            ex_valid_r <= 1'b0;
        end else begin
            ex_valid_r <= 1'b0;
        end
    end

    assign bus.id_ready   = id_ready_s;
    assign bus.ex_valid   = ex_valid_r;
    assign bus.ex_pc      = pc_r;
    assign bus.rs1_num    = use_pc_r  ? pc_r  : fwd1_s;
    assign bus.rs2_num    = use_imm_r ? imm_r : fwd2_s;
    assign bus.alu_op     = alu_op_r;
    assign bus.ex_rd_addr = rd_addr_r;
    assign bus.ex_rd_we   = rd_we_r && ex_valid_r && (rd_addr_r != 5'd0);

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [9:0]  op;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];

    id_ex_operand_stage_if #(.XLEN(32), .OPW(10)) bus ();

    id_ex_operand_stage #(.XLEN(32), .OPW(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic upc, input logic uimm, input logic [9:0] op,
                         input logic [4:0] rd, input logic we, input logic accept);
        exp_t e;
        bus.id_valid    = 1'b1;
        bus.id_pc       = pc;
        bus.id_rs1_addr = a1;
        bus.id_rs2_addr = a2;
        bus.id_rs1_data = d1;
        bus.id_rs2_data = d2;
        bus.id_imm      = imm;
        bus.id_use_pc   = upc;
        bus.id_use_imm  = uimm;
        bus.id_alu_op   = op;
        bus.id_rd_addr  = rd;
        bus.id_rd_we    = we;
        if (accept) begin
            e.pc  = pc;
            e.rs1 = upc ? pc : d1;
            e.rs2 = uimm ? imm : d2;
            e.op  = op;
            e.rd  = rd;
            e.we  = we && (rd != 5'd0);
            sb.push_back(e);
        end
        tick();
        bus.id_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"},  {31'd0, bus.ex_valid}, 32'd1);
            check({tag, "_pc"},     bus.ex_pc, e.pc);
            check({tag, "_rs1"},    bus.rs1_num, e.rs1);
            check({tag, "_rs2"},    bus.rs2_num, e.rs2);
            check({tag, "_op"},     {22'd0, bus.alu_op}, {22'd0, e.op});
            check({tag, "_rd"},     {27'd0, bus.ex_rd_addr}, {27'd0, e.rd});
            check({tag, "_rd_we"},  {31'd0, bus.ex_rd_we}, {31'd0, e.we});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_pc = 32'd0; bus.id_rs1_addr = 5'd0; bus.id_rs2_addr = 5'd0;
        bus.id_rs1_data = 32'd0; bus.id_rs2_data = 32'd0; bus.id_imm = 32'd0;
        bus.id_use_pc = 1'b0; bus.id_use_imm = 1'b0; bus.id_alu_op = 10'd0;
        bus.id_rd_addr = 5'd0; bus.id_rd_we = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b0;
        bus.mem_rd_we = 1'b0; bus.mem_rd_addr = 5'd0; bus.mem_rd_num = 32'd0;
        bus.wb_rd_we = 1'b0; bus.wb_rd_addr = 5'd0; bus.wb_rd_num = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid",    {31'd0, bus.ex_valid}, 32'd0);
        check("rst_rs1",      bus.rs1_num, 32'd0);
        check("rst_rs2",      bus.rs2_num, 32'd0);
        check("rst_op",       {22'd0, bus.alu_op}, 32'd0);
        check("rst_pc",       bus.ex_pc, 32'd0);
        check("rst_id_ready", {31'd0, bus.id_ready}, 32'd1);

        // Basic issue, then stall with a second offer that must be refused
        bus.ex_ready = 1'b0;
        issue(32'h0000_0100, 5'd1, 5'd2, 32'h0008_2296, 32'h41E1_7936, 32'd0,
              1'b0, 1'b0, 10'b00_0000_0001, 5'd3, 1'b1, 1'b1);
        pop_check("basic");
        check("basic_id_ready", {31'd0, bus.id_ready}, 32'd0);
        issue(32'h0000_0200, 5'd9, 5'd9, 32'h9999_9999, 32'h9999_9999, 32'd0,
              1'b0, 1'b0, 10'd9, 5'd9, 1'b1, 1'b0);
        #1;
        check("stall_keep_pc", bus.ex_pc, 32'h0000_0100);

        // Accept B in the same cycle A drains; rd=x0 gives no write enable
        bus.ex_ready = 1'b1;
        issue(32'h0000_0104, 5'd5, 5'd7, 32'hAAAA_0005, 32'hBBBB_0007, 32'd0,
              1'b0, 1'b0, 10'd2, 5'd0, 1'b1, 1'b1);
        bus.ex_ready = 1'b0;
        pop_check("b");

        // Forward priority on rs1=x5
        bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd5; bus.mem_rd_num = 32'h1111_1111;
        bus.wb_rd_we  = 1'b1; bus.wb_rd_addr  = 5'd5; bus.wb_rd_num  = 32'h2222_2222;
        #1;
        check("fwd_mem", bus.rs1_num, 32'h1111_1111);
        bus.mem_rd_we = 1'b0;
        #1;
        check("fwd_wb", bus.rs1_num, 32'h2222_2222);
        bus.wb_rd_we = 1'b0;
        #1;
        check("fwd_none", bus.rs1_num, 32'hAAAA_0005);

        // Stall refresh on rs2=x7
        bus.wb_rd_we = 1'b1; bus.wb_rd_addr = 5'd7; bus.wb_rd_num = 32'hDEAD_BEEF;
        #1;
        check("refresh_id_ready0", {31'd0, bus.id_ready}, 32'd0);
        tick();
        bus.wb_rd_we = 1'b0;
        #1;
        check("refresh_rs2_1", bus.rs2_num, 32'hDEAD_BEEF);
        check("refresh_id_ready1", {31'd0, bus.id_ready}, 32'd0);
        tick();
        check("refresh_rs2_2", bus.rs2_num, 32'hDEAD_BEEF);

        // x0 is never forwarded
        bus.ex_ready = 1'b1;
        issue(32'h0000_0300, 5'd0, 5'd0, 32'h1234_5678, 32'h8765_4321, 32'd0,
              1'b0, 1'b0, 10'd3, 5'd4, 1'b1, 1'b1);
        bus.ex_ready = 1'b0;
        bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd0; bus.mem_rd_num = 32'h1111_1111;
        bus.wb_rd_we  = 1'b1; bus.wb_rd_addr  = 5'd0; bus.wb_rd_num  = 32'h2222_2222;
        pop_check("x0");
        bus.mem_rd_we = 1'b0; bus.wb_rd_we = 1'b0;

        // Flush beats a simultaneous load
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b1;
        #1;
        check("flush_id_ready", {31'd0, bus.id_ready}, 32'd1);
        issue(32'h0000_0400, 5'd1, 5'd2, 32'h4444_4444, 32'h5555_5555, 32'd0,
              1'b0, 1'b0, 10'd4, 5'd6, 1'b1, 1'b0);
        bus.flush = 1'b0;
        #1;
        check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("flush_rd_we", {31'd0, bus.ex_rd_we}, 32'd0);
        check("flush_no_capture_pc", bus.ex_pc, 32'h0000_0300);

        // Load then drain
        issue(32'h0000_0500, 5'd8, 5'd9, 32'h0000_0008, 32'h0000_0009, 32'd0,
              1'b0, 1'b0, 10'd5, 5'd10, 1'b1, 1'b1);
        pop_check("drain");
        tick();
        check("drain_valid", {31'd0, bus.ex_valid}, 32'd0);

        // PC/immediate select masks forwarding
        issue(32'h0000_1000, 5'd5, 5'd6, 32'h7777_7777, 32'h6666_6666, 32'hFFFF_F800,
              1'b1, 1'b1, 10'd6, 5'd11, 1'b0, 1'b1);
        bus.ex_ready = 1'b0;
        bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd5; bus.mem_rd_num = 32'h1111_1111;
        bus.wb_rd_we  = 1'b1; bus.wb_rd_addr  = 5'd6; bus.wb_rd_num  = 32'h3333_3333;
        pop_check("sel");
        bus.mem_rd_we = 1'b0; bus.wb_rd_we = 1'b0;

        // Asynchronous reset between edges while holding
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",    {31'd0, bus.ex_valid}, 32'd0);
        check("arst_rs1",      bus.rs1_num, 32'd0);
        check("arst_op",       {22'd0, bus.alu_op}, 32'd0);
        check("arst_id_ready", {31'd0, bus.id_ready}, 32'd1);
        rst = 1'b0;
        tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
